// File: rtl/slurm_cpu_fetch_unit.sv
// slurm_cpu_fetch_unit: CPU memory front end with an epoch-tagged prefetch queue,
// a priority load/store channel, branch flush and halt/wake.
module slurm_cpu_fetch_unit #(
    parameter int BITS = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0,
    parameter int MASK_BITS = BITS / 8
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    load_pc,
    input  logic [ADDRESS_BITS-1:0] pc_in,
    input  logic                    halt,
    input  logic                    wake,
    input  logic                    ls_valid,
    input  logic                    ls_wr,
    input  logic [ADDRESS_BITS-1:0] ls_address,
    input  logic [BITS-1:0]         ls_data,
    input  logic [MASK_BITS-1:0]    ls_wr_mask,
    output logic                    ls_ready,
    output logic                    ls_done,
    output logic [BITS-1:0]         ls_rdata,
    output logic                    instr_valid,
    output logic [BITS-1:0]         instr,
    output logic [ADDRESS_BITS-1:0] instr_pc,
    input  logic                    instr_ready,
    output logic                    is_halted,
    output logic [ADDRESS_BITS-1:0] memory_address,
    output logic [BITS-1:0]         memory_out,
    output logic                    memory_valid,
    output logic                    memory_wr,
    output logic [MASK_BITS-1:0]    memory_wr_mask,
    input  logic                    memory_ready,
    input  logic [BITS-1:0]         memory_in
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QMAX = (CW + 1)'(DEPTH);
    localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(MASK_BITS);

    typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;
    state_t state, state_n;

    logic [ADDRESS_BITS-1:0] fetch_pc, fetch_base, resp_pc;
    logic epoch, req_fetch, req_epoch;
    logic resp_valid, resp_fetch, resp_epoch, resp_wr;
    logic [BITS-1:0] q_data [DEPTH];
    logic [ADDRESS_BITS-1:0] q_pc [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0] occ;
    logic grant, slot_free, ls_new, drop, drained, fetch_ok, issue_ls, issue_fetch, push, pop;

    // occ reserves queue slots for fetches on the bus or returning, so a push never overflows
    always_comb begin
        grant = memory_valid & memory_ready;
        slot_free = ~memory_valid | memory_ready;
        ls_new = ls_valid & ~(memory_valid & ~req_fetch);
        drop = load_pc & memory_valid & req_fetch & ~memory_ready;
        drained = ~(memory_valid & req_fetch) & ~(resp_valid & resp_fetch);
        state_n = wake ? RUN :
                  (state == RUN && halt) ? HALTING :
                  (state == HALTING && drained) ? HALTED : state;
        occ = {1'b0, count} + (CW + 1)'(memory_valid & req_fetch) + (CW + 1)'(resp_valid & resp_fetch);
        fetch_ok = state_n == RUN && (load_pc || occ < QMAX);
        issue_ls = slot_free & ls_new;
        issue_fetch = slot_free & ~ls_new & fetch_ok;
        fetch_base = load_pc ? pc_in : fetch_pc;
        push = resp_valid & resp_fetch & (resp_epoch == epoch) & ~load_pc;
        pop = instr_ready & instr_valid;
    end

    assign ls_ready = grant & ~req_fetch;
    assign is_halted = state == HALTED;
    assign instr_valid = count != '0;
    assign instr = instr_valid ? q_data[rd_ptr] : '0;
    assign instr_pc = instr_valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (RSTb) begin
            state <= RUN;
            fetch_pc <= RESET_PC;
            epoch <= 1'b0;
            memory_valid <= 1'b0;
            memory_wr <= 1'b0;
            memory_address <= '0;
            memory_out <= '0;
            memory_wr_mask <= '0;
            req_fetch <= 1'b0;
            req_epoch <= 1'b0;
            resp_valid <= 1'b0;
            resp_fetch <= 1'b0;
            resp_epoch <= 1'b0;
            resp_wr <= 1'b0;
            resp_pc <= '0;
            ls_done <= 1'b0;
            ls_rdata <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            fetch_pc <= issue_fetch ? fetch_base + STEP : fetch_base;
            epoch <= epoch ^ load_pc;
            resp_valid <= grant;
            resp_fetch <= req_fetch;
            resp_epoch <= req_epoch;
            resp_wr <= memory_wr;
            resp_pc <= memory_address;
            ls_done <= resp_valid & ~resp_fetch;
            if (resp_valid && !resp_fetch && !resp_wr)
                ls_rdata <= memory_in;
            if (issue_ls || issue_fetch) begin
                memory_valid <= 1'b1;
                memory_address <= issue_ls ? ls_address : fetch_base;
                memory_out <= issue_ls ? ls_data : '0;
                memory_wr <= issue_ls & ls_wr;
                memory_wr_mask <= (issue_ls && ls_wr) ? ls_wr_mask : '1;
                req_fetch <= issue_fetch;
                req_epoch <= epoch ^ load_pc;
            end else if (slot_free || drop) begin
                memory_valid <= 1'b0;
                memory_wr <= 1'b0;
            end
            if (load_pc) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count <= '0;
            end else begin
                rd_ptr <= rd_ptr + PW'(pop);
                wr_ptr <= wr_ptr + PW'(push);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_data[wr_ptr] <= memory_in;
            q_pc[wr_ptr] <= resp_pc;
        end
    end
endmodule

// File: tb/tb_slurm_cpu_fetch_unit.sv
// tb_slurm_cpu_fetch_unit: scoreboard bench; stimulus queues expected instructions and
// load results, negedge monitor pops and compares them as the DUT presents them.
module tb_slurm_cpu_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_pc = 1'b0, halt = 1'b0, wake = 1'b0;
    logic [15:0] pc_in = '0;
    logic ls_valid = 1'b0, ls_wr = 1'b0;
    logic [15:0] ls_address = '0, ls_data = '0;
    logic [1:0] ls_wr_mask = '0;
    logic ls_ready, ls_done, instr_valid, is_halted, memory_valid, memory_wr;
    logic [15:0] ls_rdata, instr, instr_pc, memory_address, memory_out;
    logic [1:0] memory_wr_mask;
    logic instr_ready = 1'b0;
    logic memory_ready = 1'b1;
    logic [15:0] memory_in;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, rd_grants = 0, valid_cycles = 0, ready_cyc = 0;
    logic [15:0] last_rd_addr = '0, st_addr = '0, st_data = '0;
    logic [1:0] st_mask = '0;
    logic [15:0] exp_pc[$];
    logic [15:0] exp_ls[$];
    int pop_times[$];

    slurm_cpu_fetch_unit #(.RESET_PC(16'h0100)) dut (
        .CLK(clk), .RSTb(rst), .load_pc(load_pc), .pc_in(pc_in), .halt(halt), .wake(wake),
        .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_address(ls_address), .ls_data(ls_data),
        .ls_wr_mask(ls_wr_mask), .ls_ready(ls_ready), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .is_halted(is_halted), .memory_address(memory_address), .memory_out(memory_out),
        .memory_valid(memory_valid), .memory_wr(memory_wr), .memory_wr_mask(memory_wr_mask),
        .memory_ready(memory_ready), .memory_in(memory_in)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return (a == 16'h2000) ? 16'hBEEF : a ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_seq(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(start + 16'(2 * i));
    endtask

    task automatic pop_n(input int n, input int budget);
        int target;
        target = pop_times.size() + n;
        instr_ready = 1'b1;
        for (int i = 0; i < budget && pop_times.size() < target; i++) @(posedge clk);
        #1 instr_ready = 1'b0;
        check("pop_count", pop_times.size(), target);
    endtask

    // memory arbiter model: read data one cycle after the grant, stores recorded
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memory_valid && memory_ready) begin
            memory_in <= mdata(memory_address);
            if (memory_wr) begin
                st_addr <= memory_address;
                st_data <= memory_out;
                st_mask <= memory_wr_mask;
            end else begin
                rd_grants <= rd_grants + 1;
                last_rd_addr <= memory_address;
            end
        end else begin
            memory_in <= 16'hDEAD;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (memory_valid) valid_cycles++;
        if (ls_ready) ready_cyc = cyc;
        if (instr_valid && instr_ready) begin
            pop_times.push_back(cyc);
            if (exp_pc.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL instr_unexpected: got pc %h, none expected", instr_pc);
            end else begin
                e = exp_pc.pop_front();
                check("instr_pc", instr_pc, e);
                check("instr_data", instr, mdata(e));
            end
        end
        if (ls_done) begin
            if (exp_ls.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ls_unexpected: got ls_done with rdata %h, none expected", ls_rdata);
            end else begin
                e = exp_ls.pop_front();
                check("ls_rdata", ls_rdata, e);
                check("ls_latency", cyc - ready_cyc, 2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, p0, g0, v0;
        // reset state
        tick(3);
        check("rst_memory_valid", memory_valid, 0);
        check("rst_memory_wr", memory_wr, 0);
        check("rst_memory_address", memory_address, 0);
        check("rst_memory_out", memory_out, 0);
        check("rst_memory_wr_mask", memory_wr_mask, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_ls_ready", ls_ready, 0);
        check("rst_ls_done", ls_done, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_is_halted", is_halted, 0);
        rst = 1'b0;
        tick(1);
        check("first_fetch_valid", memory_valid, 1);
        check("first_fetch_addr", memory_address, 16'h0100);
        tick(10);
        check("prefetch_count", rd_grants, 4);
        check("prefetch_last_addr", last_rd_addr, 16'h0106);
        check("prefetch_stopped", memory_valid, 0);
        check("head_valid", instr_valid, 1);
        check("head_pc", instr_pc, 16'h0100);
        check("head_data", instr, mdata(16'h0100));
        // streaming
        expect_seq(16'h0100, 8);
        pop_n(8, 40);
        tick(6);
        // load takes the bus ahead of the refetch after a flush
        load_pc = 1'b1;
        pc_in = 16'h3000;
        ls_valid = 1'b1;
        ls_wr = 1'b0;
        ls_address = 16'h2000;
        exp_ls.push_back(16'hBEEF);
        tick(1);
        load_pc = 1'b0;
        check("flush_instr_valid", instr_valid, 0);
        check("load_addr", memory_address, 16'h2000);
        check("load_ready", ls_ready, 1);
        check("load_mask", memory_wr_mask, 2'b11);
        tick(1);
        ls_valid = 1'b0;
        check("refetch_addr", memory_address, 16'h3000);
        tick(8);
        // store held until the grant
        memory_ready = 1'b0;
        ls_valid = 1'b1;
        ls_wr = 1'b1;
        ls_address = 16'h2002;
        ls_data = 16'h1234;
        ls_wr_mask = 2'b10;
        exp_ls.push_back(16'hBEEF);
        tick(3);
        check("store_valid_held", memory_valid, 1);
        check("store_wr", memory_wr, 1);
        check("store_mask", memory_wr_mask, 2'b10);
        check("store_addr", memory_address, 16'h2002);
        check("store_data", memory_out, 16'h1234);
        check("store_not_ready", ls_ready, 0);
        memory_ready = 1'b1;
        @(negedge clk);
        check("store_ready", ls_ready, 1);
        @(posedge clk);
        #1 ls_valid = 1'b0;
        ls_wr = 1'b0;
        tick(6);
        check("mem_store_addr", st_addr, 16'h2002);
        check("mem_store_data", st_data, 16'h1234);
        check("mem_store_mask", st_mask, 2'b10);
        check("store_no_push", instr_pc, 16'h3000);
        expect_seq(16'h3000, 4);
        pop_n(4, 40);
        tick(8);
        // flush in the grant cycle of a fetch
        memory_ready = 1'b0;
        tick(1);
        expect_seq(16'h3008, 1);
        pop_n(1, 10);
        tick(2);
        check("held_fetch_valid", memory_valid, 1);
        check("held_fetch_addr", memory_address, 16'h3010);
        memory_ready = 1'b1;
        load_pc = 1'b1;
        pc_in = 16'h4000;
        tick(1);
        load_pc = 1'b0;
        check("flush2_instr_valid", instr_valid, 0);
        check("flush2_fetch_addr", memory_address, 16'h4000);
        expect_seq(16'h4000, 2);
        pop_n(2, 20);
        // wrap across 0xFFFE with one instruction per cycle
        load_pc = 1'b1;
        pc_in = 16'hFFFA;
        tick(1);
        load_pc = 1'b0;
        t0 = cyc;
        p0 = pop_times.size();
        expect_seq(16'hFFFA, 6);
        pop_n(6, 30);
        if (pop_times.size() >= p0 + 6) begin
            check("fetch_latency", pop_times[p0] - t0, 2);
            check("stream_rate", pop_times[p0 + 5] - pop_times[p0], 5);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_pops: got %0d pops, expected 6", pop_times.size() - p0);
        end
        // halt / wake
        tick(8);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        for (int i = 0; i < 20 && !is_halted; i++) tick(1);
        check("halted", is_halted, 1);
        v0 = valid_cycles;
        expect_seq(16'h0006, 4);
        pop_n(4, 20);
        tick(5);
        check("halted_no_fetch", valid_cycles - v0, 0);
        check("halted_empty", instr_valid, 0);
        check("still_halted", is_halted, 1);
        wake = 1'b1;
        tick(1);
        wake = 1'b0;
        check("woken", is_halted, 0);
        check("wake_fetch_valid", memory_valid, 1);
        check("wake_fetch_addr", memory_address, 16'h000E);
        tick(8);
        halt = 1'b1;
        wake = 1'b1;
        tick(1);
        halt = 1'b0;
        wake = 1'b0;
        tick(4);
        check("halt_wake_run", is_halted, 0);
        g0 = rd_grants;
        expect_seq(16'h000E, 4);
        pop_n(4, 20);
        tick(6);
        check("fetching_after_halt_wake", rd_grants > g0, 1);
        check("exp_instr_drained", exp_pc.size(), 0);
        check("exp_ls_drained", exp_ls.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/slurm_cpu_fetch_unit.md
# slurm_cpu_fetch_unit

Parametrised successor to the slurm16 CPU memory front end. The block owns the single CPU port to the memory arbiter and provides two things. First, a DEPTH-entry instruction prefetch queue tagged with the fetch PC. Second, a load/store channel that takes priority over fetches. It supports branch flush (redirect) with stale-response discard, plus halt/wake. It sits between the memory arbiter and the decode/execute pipeline.

## Interface
Parameters:
- BITS, 16, data width; multiple of 8.
- ADDRESS_BITS, 16, byte-address width.
- DEPTH, 4, prefetch queue entries; power of 2, ≥2.
- RESET_PC, 0, fetch address after reset.
- MASK_BITS, BITS/8, derived; byte-lane write mask width.

Ports:
- CLK  in  1  clock.
- RSTb  in  1  synchronous, active-high reset.
- load_pc  in  1  redirect: flush the queue and refetch from pc_in.
- pc_in  in  ADDRESS_BITS  redirect target.
- halt  in  1  request to stop fetching.
- wake  in  1  resume fetching.
- ls_valid  in  1  load/store request; held until ls_ready.
- ls_wr  in  1  1 = store.
- ls_address  in  ADDRESS_BITS  load/store address.
- ls_data  in  BITS  store data.
- ls_wr_mask  in  MASK_BITS  store byte mask.
- ls_ready  out  1  request accepted (granted) this cycle.
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  BITS  load data, valid with ls_done.
- instr_valid  out  1  queue head valid.
- instr  out  BITS  queue head instruction.
- instr_pc  out  ADDRESS_BITS  address of instr.
- instr_ready  in  1  pop the head when instr_valid.
- is_halted  out  1  in HALTED state.
- memory_address  out  ADDRESS_BITS  to arbiter.
- memory_out  out  BITS  write data.
- memory_valid  out  1  request.
- memory_wr  out  1  write.
- memory_wr_mask  out  MASK_BITS  write mask; all-ones on reads.
- memory_ready  in  1  arbiter grant.
- memory_in  in  BITS  read data, one cycle after the grant.

## Operation
- Request rule: memory_valid/address/wr/out/mask are registered and held stable until a cycle with memory_ready=1 (the grant). A new request may be driven in the cycle after a grant. At most one request is awaiting a grant; at most one response (the cycle after the grant) is in flight.
- Priority: a pending ls_valid wins over a fetch at every issue decision. A fetch already on the bus is not withdrawn; ls waits for its grant.
- Fetch issue: only when count + inflight_fetch < DEPTH, not halting/halted, and no ls pending. On grant, fetch_pc advances by MASK_BITS, wrapping modulo 2^ADDRESS_BITS.
- Each response carries a tag {is_fetch, epoch, pc}. A fetch response pushes {memory_in, pc} into the queue if its epoch matches, and is dropped otherwise. A load response registers ls_rdata.
- load_pc: clears the queue, sets fetch_pc=pc_in, toggles epoch. An un-granted fetch request is dropped (memory_valid deasserts next cycle). A fetch with a grant already received completes and is discarded. load_pc in the same cycle as a pop or push: the flush wins, count=0.
- FSM states:
  - RUN: fetching.
  - HALTING: entered from RUN on halt. No new fetches; wait for pending/in-flight fetches to drain.
  - HALTED: reached once drained. is_halted=1.
  - wake in HALTING/HALTED returns to RUN. halt and wake in the same cycle: wake wins.
  - Load/store is served in all states. load_pc while halted updates fetch_pc and stays HALTED.
- Queue: circular, log2(DEPTH)-bit pointers, count 0..DEPTH. Simultaneous push and pop at full or empty is legal, and count is unchanged. Pop when empty is ignored.

## Timing
- Reset: memory_valid=0, memory_wr=0, memory_address=0, memory_out=0, memory_wr_mask=0, instr_valid=0, instr=0, instr_pc=0, ls_ready=0, ls_done=0, ls_rdata=0, is_halted=0. Internal: fetch_pc=RESET_PC, epoch=0, state RUN, queue empty.
- First fetch: memory_valid=1 in the first cycle after RSTb deasserts.
- Fetch latency: grant in cycle N, memory_in sampled in N+1, instr_valid at N+2. Back-to-back grants yield one instruction per cycle.
- Load/store: ls_ready=1 in the grant cycle N. ls_done pulses in N+2 for both reads and writes; ls_rdata is valid in N+2 and held until the next load.
- Flush: instr_valid=0 in the cycle after load_pc. The first fetch of pc_in is on the bus that cycle unless ls is pending.
- Reset mid-operation aborts everything, and any response from the next cycle is ignored.

## Test plan
- Reset then memory_ready always 1, RESET_PC=0x0100, instr_ready=0 -> exactly 4 fetches at 0x0100..0x0106. memory_valid then drops; instr_pc=0x0100 at the head.
- Steady streaming with instr_ready=1 -> instr_pc increments by 2 each cycle; address 0xFFFE wraps to 0x0000.
- ls_valid load of 0x2000 while fetches are pending, memory_in=0xBEEF -> load granted first, ls_done with ls_rdata=0xBEEF two cycles after ls_ready.
- Store with ls_wr_mask=2'b10 -> memory_wr=1 and memory_wr_mask=2'b10 held until the grant; no queue push.
- load_pc=0x4000 in the grant cycle of a fetch to 0x0108 -> the 0x0108 data is discarded; the next instr_pc is 0x4000.
- halt during streaming -> is_halted=1 after the in-flight fetch drains; no memory_valid for fetches. halt+wake in the same cycle -> stays RUN.
